fwd_hazard_ctrl: RTL and testbench

- Control end of the EX-stage operand-forwarding path: tracks destination-register state for the EX, MEM and WB stages.
- Generates the 2-bit select codes consumed by the EX-stage forwarding muxes for operands A and B.
- Detects load-use hazards and drives stall/bubble insertion at the ID/EX boundary.
- Sits beside the ID/EX, EX/MEM and MEM/WB pipeline registers and honours the data-cache stall.

---
 rtl/fwd_hazard_ctrl_if.sv | 50 +++++
 rtl/fwd_hazard_ctrl.sv | 119 +++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/fwd_hazard_ctrl_if.sv
// ID-stage instruction fields, pipeline control and forwarding/stall results
// exchanged between the pipeline (master) and the hazard controller (slave).
interface fwd_hazard_ctrl_if #(
  parameter int unsigned REG_AW = 5
);

  logic [REG_AW-1:0] id_rs1_i;
  logic [REG_AW-1:0] id_rs2_i;
  logic              id_use_rs1_i;
  logic              id_use_rs2_i;
  logic [REG_AW-1:0] id_rd_i;
  logic              id_regwrite_i;
  logic              id_memread_i;
  logic              flush_i;
  logic              mem_stall_i;
  logic [1:0]        forward_a_o;
  logic [1:0]        forward_b_o;
  logic              stall_o;

  modport master (
    output id_rs1_i,
    output id_rs2_i,
    output id_use_rs1_i,
    output id_use_rs2_i,
    output id_rd_i,
    output id_regwrite_i,
    output id_memread_i,
    output flush_i,
    output mem_stall_i,
    input  forward_a_o,
    input  forward_b_o,
    input  stall_o
  );

  modport slave (
    input  id_rs1_i,
    input  id_rs2_i,
    input  id_use_rs1_i,
    input  id_use_rs2_i,
    input  id_rd_i,
    input  id_regwrite_i,
    input  id_memread_i,
    input  flush_i,
    input  mem_stall_i,
    output forward_a_o,
    output forward_b_o,
    output stall_o
  );

endinterface

// File: rtl/fwd_hazard_ctrl.sv
// EX-stage forwarding select and load-use stall control. Mirrors the register
// fields held in ID/EX, EX/MEM and MEM/WB and derives mux selects from them.
module fwd_hazard_ctrl #(
  parameter int unsigned REG_AW = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  fwd_hazard_ctrl_if.slave   bus
);

  localparam int unsigned AW = REG_AW;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b10;
  localparam logic [1:0] FWD_WB   = 2'b01;

  typedef struct packed {
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic          use1;
    logic          use2;
    logic [AW-1:0] rd;
    logic          regwrite;
    logic          memread;
  } ex_stage_t;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic          regwrite;
    logic          memread;
  } mem_stage_t;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic          regwrite;
  } wb_stage_t;

  ex_stage_t  ex_q,  ex_d;
  mem_stage_t mem_q, mem_d;
  wb_stage_t  wb_q,  wb_d;

  logic       stall_c;
  logic       mem_wr_valid_c;
  logic       wb_wr_valid_c;
  logic [1:0] fwd_a_c;
  logic [1:0] fwd_b_c;
  logic       id_hit_rs1_c;
  logic       id_hit_rs2_c;

  // Load-use: EX holds a load whose rd the ID instruction reads; muted during freeze.
  always_comb begin
    id_hit_rs1_c = bus.id_use_rs1_i && (bus.id_rs1_i == ex_q.rd);
    id_hit_rs2_c = bus.id_use_rs2_i && (bus.id_rs2_i == ex_q.rd);
    stall_c      = !bus.mem_stall_i && ex_q.memread && (ex_q.rd != AW'(0)) &&
                   (id_hit_rs1_c || id_hit_rs2_c);
  end

  // Forward selects depend on stage state only; EX/MEM has priority (newest).
  always_comb begin
    mem_wr_valid_c = mem_q.regwrite && (mem_q.rd != AW'(0));
    wb_wr_valid_c  = wb_q.regwrite && (wb_q.rd != AW'(0));

    fwd_a_c = FWD_NONE;
    if (ex_q.use1 && mem_wr_valid_c && (mem_q.rd == ex_q.rs1)) begin
      fwd_a_c = FWD_MEM;
    end else if (ex_q.use1 && wb_wr_valid_c && (wb_q.rd == ex_q.rs1)) begin
      fwd_a_c = FWD_WB;
    end

    fwd_b_c = FWD_NONE;
    if (ex_q.use2 && mem_wr_valid_c && (mem_q.rd == ex_q.rs2)) begin
      fwd_b_c = FWD_MEM;
    end else if (ex_q.use2 && wb_wr_valid_c && (wb_q.rd == ex_q.rs2)) begin
      fwd_b_c = FWD_WB;
    end
  end

  // Stage advance: freeze holds everything, otherwise shift and load EX.
  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!bus.mem_stall_i) begin
      wb_d.rd        = mem_q.rd;
      wb_d.regwrite  = mem_q.regwrite;
      mem_d.rd       = ex_q.rd;
      mem_d.regwrite = ex_q.regwrite;
      mem_d.memread  = ex_q.memread;
      if (stall_c || bus.flush_i) begin
        ex_d = '0;
      end else begin
        ex_d.rs1      = bus.id_rs1_i;
        ex_d.rs2      = bus.id_rs2_i;
        ex_d.use1     = bus.id_use_rs1_i;
        ex_d.use2     = bus.id_use_rs2_i;
        ex_d.rd       = bus.id_rd_i;
        ex_d.regwrite = bus.id_regwrite_i;
        ex_d.memread  = bus.id_memread_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  assign bus.forward_a_o = fwd_a_c;
  assign bus.forward_b_o = fwd_b_c;
  assign bus.stall_o     = stall_c;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed-vector bench for fwd_hazard_ctrl with a queue-based scoreboard.
module tb_fwd_hazard_ctrl;

  logic clk   = 1'b0;
  logic rst_i = 1'b0;
  int   cyc_cnt = 0;
  int   n_chk   = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  fwd_hazard_ctrl_if #(.REG_AW(5)) bus ();

  fwd_hazard_ctrl #(.REG_AW(5)) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  typedef struct {
    int         cyc;
    string      name;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       st;
  } exp_t;

  exp_t q[$];
  exp_t e;

  // Monitor: compare every expectation queued for the current cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc_cnt) begin
      e = q.pop_front();
      n_chk++;
      if (bus.forward_a_o === e.fa && bus.forward_b_o === e.fb && bus.stall_o === e.st) begin
        n_pass++;
      end else begin
        $display("FAIL %s: got fa=%b fb=%b stall=%b, expected fa=%b fb=%b stall=%b",
                 e.name, bus.forward_a_o, bus.forward_b_o, bus.stall_o, e.fa, e.fb, e.st);
      end
    end
  end

  task automatic apply(input string name,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2,
                       input logic [4:0] rd, input logic rw, input logic mr,
                       input logic fl, input logic ms,
                       input logic [1:0] fa, input logic [1:0] fb, input logic st);
    exp_t x;
    bus.id_rs1_i      = rs1;
    bus.id_rs2_i      = rs2;
    bus.id_use_rs1_i  = u1;
    bus.id_use_rs2_i  = u2;
    bus.id_rd_i       = rd;
    bus.id_regwrite_i = rw;
    bus.id_memread_i  = mr;
    bus.flush_i       = fl;
    bus.mem_stall_i   = ms;
    x.cyc  = cyc_cnt;
    x.name = name;
    x.fa   = fa;
    x.fb   = fb;
    x.st   = st;
    q.push_back(x);
  endtask

  task automatic step(input string name,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2,
                      input logic [4:0] rd, input logic rw, input logic mr,
                      input logic fl, input logic ms,
                      input logic [1:0] fa, input logic [1:0] fb, input logic st);
    @(posedge clk);
    #1;
    apply(name, rs1, rs2, u1, u2, rd, rw, mr, fl, ms, fa, fb, st);
  endtask

  task automatic rand_step(input string name, input logic ms);
    step(name, 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
         5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), ms, 2'b00, 2'b00, 1'b0);
  endtask

  initial begin
    // Reset held with random ID traffic: outputs zero immediately and on every edge
    #1;
    apply("rst_async", 5'd3, 5'd3, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    for (int i = 0; i < 3; i++) rand_step("rst_hold", 1'b0);
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    apply("rst_rel", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);

    // EX/MEM forward on both operands
    step("exmem_w",   5'd0, 5'd0, 1'b0, 1'b0, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    step("exmem_r",   5'd5, 5'd5, 1'b1, 1'b1, 5'd6,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    step("exmem_fwd", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 1'b0);
    step("exmem_aft", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);

    // MEM/WB forward with an independent instruction between
    step("wb_w",      5'd0, 5'd0, 1'b0, 1'b0, 5'd7,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    step("wb_ind",    5'd1, 5'd2, 1'b1, 1'b1, 5'd8,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    step("wb_r",      5'd7, 5'd9, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    step("wb_fwd",    5'd0, 5'd0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0);

    // Two writers of x7: newest (EX/MEM) wins
    step("prio_w1",   5'd0, 5'd0, 1'b0, 1'b0, 5'd7,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    step("prio_w2",   5'd0, 5'd0, 1'b0, 1'b0, 5'd7,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    step("prio_r",    5'd7, 5'd7, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    step("prio_fwd",  5'd0, 5'd0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 1'b0);

    // x0 never forwards and a load to x0 never stalls
    step("x0_w",      5'd0, 5'd0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    step("x0_r",      5'd0, 5'd0, 1'b1, 1'b1, 5'd11, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    step("x0_fwd",    5'd0, 5'd0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    step("x0_lduse",  5'd0, 5'd0, 1'b1, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    step("x0_ld_fwd", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);

    // rs2 matches a writer but is not used
    step("nouse_w",   5'd0,  5'd0,  1'b0, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    step("nouse_r",   5'd13, 5'd12, 1'b1, 1'b0, 5'd14, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    step("nouse_fwd", 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);

    // Load-use: one-cycle stall, bubble, then MEM/WB forward
    step("lu_ld",     5'd0, 5'd0, 1'b0, 1'b0, 5'd3,  1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    step("lu_stall",  5'd3, 5'd4, 1'b1, 1'b1, 5'd14, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1);
    step("lu_bubble", 5'd3, 5'd4, 1'b1, 1'b1, 5'd14, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    step("lu_fwd",    5'd0, 5'd0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0);

    // Flush together with a load-use stall: single bubble, stall still asserts
    step("fs_ld",     5'd0, 5'd0, 1'b0, 1'b0, 5'd3,  1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    step("fs_both",   5'd0, 5'd3, 1'b0, 1'b1, 5'd14, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1);
    step("fs_bubble", 5'd0, 5'd3, 1'b0, 1'b1, 5'd14, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    step("fs_fwd",    5'd0, 5'd0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0);

    // Flushed writer must never forward
    step("fl_w",      5'd0,  5'd0,  1'b0, 1'b0, 5'd15, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
    step("fl_r",      5'd15, 5'd15, 1'b1, 1'b1, 5'd16, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    step("fl_fwd",    5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);

    // Cache freeze while forwarding 10, then resume
    step("fz_w",      5'd0,  5'd0,  1'b0, 1'b0, 5'd20, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    step("fz_r",      5'd20, 5'd20, 1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    step("fz_fwd",    5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b10, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step("fz_hold", 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
           5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b1, 2'b10, 2'b10, 1'b0);
    end
    step("fz_rel",    5'd20, 5'd0,  1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 1'b0);
    step("fz_resume", 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0);

    // Load-use masked during freeze, then fires once the freeze lifts
    step("fzl_ld",    5'd0,  5'd0,  1'b0, 1'b0, 5'd22, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    step("fzl_mask",  5'd22, 5'd0,  1'b1, 1'b0, 5'd23, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0);
    step("fzl_stall", 5'd22, 5'd0,  1'b1, 1'b0, 5'd23, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1);
    step("fzl_bub",   5'd22, 5'd0,  1'b1, 1'b0, 5'd23, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    step("fzl_fwd",   5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0);

    // Mid-operation reset wipes in-flight state
    step("mr_w",      5'd0,  5'd0,  1'b0, 1'b0, 5'd25, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    step("mr_r",      5'd0,  5'd0,  1'b0, 1'b0, 5'd26, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    step("mr_pre",    5'd25, 5'd26, 1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    step("mr_fwd",    5'd25, 5'd25, 1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 1'b0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    apply("mr_rst",   5'd25, 5'd25, 1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    apply("mr_rel",   5'd25, 5'd26, 1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    step("mr_after",  5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (q.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
